// File: rtl/sine_period_detector_if.sv
// Sample stream in, period/tuning-word measurement out, for
// sine_period_detector. The master drives samples; the slave is the detector.
interface sine_period_detector_if;
    logic        sample_valid;
    logic [9:0]  sample;
    logic        meas_valid;
    logic [11:0] period;
    logic [9:0]  tuning_word;
    logic [9:0]  peak;
    logic [9:0]  trough;
    logic        locked;
    logic        timeout;

    modport master (
        output sample_valid, sample,
        input  meas_valid, period, tuning_word, peak, trough, locked, timeout
    );

    modport slave (
        input  sample_valid, sample,
        output meas_valid, period, tuning_word, peak, trough, locked, timeout
    );
endinterface

// File: rtl/sine_period_detector.sv
// sine_period_detector: counts samples between hysteretic rising crossings
// of a DDS sine and recovers the phase step as floor(1024/period).
module sine_period_detector #(
    parameter int MID        = 100,
    parameter int HYST       = 8,
    parameter int MAX_PERIOD = 4095
) (
    input logic                   clk,
    input logic                   rst_n,
    sine_period_detector_if.slave io
);
    localparam logic [9:0]  HI_LVL   = 10'(MID + HYST);
    localparam logic [9:0]  LO_LVL   = 10'(MID - HYST);
    localparam logic [11:0] CNT_LAST = 12'(MAX_PERIOD - 2);
    localparam logic [3:0]  DIV_LAST = 4'd11;

    typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_DIVIDE} state_e;
    typedef enum logic [1:0] {R_UNKNOWN, R_LOW, R_HIGH} region_e;

    state_e      state_q, state_d;
    region_e     region_q, region_d;
    logic [11:0] cnt_q, cnt_d;
    logic [9:0]  tmax_q, tmax_d;
    logic [9:0]  tmin_q, tmin_d;
    logic [11:0] div_q, div_d;
    logic [9:0]  pk_q, pk_d;
    logic [9:0]  tr_q, tr_d;
    logic [11:0] rem_q, rem_d;
    logic [10:0] dvd_q, dvd_d;
    logic [10:0] quo_q, quo_d;
    logic [3:0]  iter_q, iter_d;
    logic        mv_q, mv_d;
    logic        to_q, to_d;
    logic [11:0] period_q, period_d;
    logic [9:0]  tw_q, tw_d;
    logic [9:0]  peak_q, peak_d;
    logic [9:0]  trough_q, trough_d;
    logic        locked_q, locked_d;

    logic        acc;
    logic        hi_s;
    logic        lo_s;
    logic        ev;
    logic        tmo;
    logic [12:0] trial;
    logic        fits;
    logic [9:0]  ev_max;
    logic [9:0]  ev_min;

    assign acc    = io.sample_valid;
    assign hi_s   = io.sample >= HI_LVL;
    assign lo_s   = io.sample <= LO_LVL;
    assign ev     = acc && (region_q == R_LOW) && hi_s;
    assign tmo    = acc && !ev && (state_q != S_SEARCH) && (cnt_q == CNT_LAST);
    assign trial  = {rem_q, dvd_q[10]};
    assign fits   = trial >= {1'b0, div_q};
    assign ev_max = (io.sample > tmax_q) ? io.sample : tmax_q;
    assign ev_min = (io.sample < tmin_q) ? io.sample : tmin_q;

    assign io.meas_valid  = mv_q;
    assign io.timeout     = to_q;
    assign io.period      = period_q;
    assign io.tuning_word = tw_q;
    assign io.peak        = peak_q;
    assign io.trough      = trough_q;
    assign io.locked      = locked_q;

    // Next state: region tracking, divider iteration, crossing/timeout handling
    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        cnt_d    = cnt_q;
        tmax_d   = tmax_q;
        tmin_d   = tmin_q;
        div_d    = div_q;
        pk_d     = pk_q;
        tr_d     = tr_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        quo_d    = quo_q;
        iter_d   = iter_q;
        mv_d     = 1'b0;
        to_d     = 1'b0;
        period_d = period_q;
        tw_d     = tw_q;
        peak_d   = peak_q;
        trough_d = trough_q;
        locked_d = locked_q;

        if (acc) begin
            if (hi_s) begin
                region_d = R_HIGH;
            end else if (lo_s) begin
                region_d = R_LOW;
            end
        end

        if (state_q == S_DIVIDE && !tmo) begin
            if (iter_q != DIV_LAST) begin
                rem_d  = fits ? 12'(trial - {1'b0, div_q}) : trial[11:0];
                quo_d  = {quo_q[9:0], fits};
                dvd_d  = {dvd_q[9:0], 1'b0};
                iter_d = iter_q + 4'd1;
            end else begin
                mv_d     = 1'b1;
                locked_d = 1'b1;
                period_d = div_q;
                tw_d     = quo_q[10] ? 10'd1023 : quo_q[9:0];
                peak_d   = pk_q;
                trough_d = tr_q;
                state_d  = S_MEASURE;
            end
        end

        case (state_q)
            S_SEARCH: begin
                if (ev) begin
                    cnt_d   = '0;
                    tmax_d  = io.sample;
                    tmin_d  = io.sample;
                    state_d = S_MEASURE;
                end
            end
            S_MEASURE, S_DIVIDE: begin
                if (ev) begin
                    if (state_q == S_MEASURE) begin
                        div_d   = cnt_q + 12'd1;
                        pk_d    = ev_max;
                        tr_d    = ev_min;
                        rem_d   = '0;
                        dvd_d   = 11'h400;
                        quo_d   = '0;
                        iter_d  = '0;
                        state_d = S_DIVIDE;
                    end
                    cnt_d  = '0;
                    tmax_d = io.sample;
                    tmin_d = io.sample;
                end else if (tmo) begin
                    to_d     = 1'b1;
                    locked_d = 1'b0;
                    region_d = R_UNKNOWN;
                    cnt_d    = '0;
                    state_d  = S_SEARCH;
                end else if (acc) begin
                    cnt_d  = cnt_q + 12'd1;
                    tmax_d = ev_max;
                    tmin_d = ev_min;
                end
            end
            default: state_d = S_SEARCH;
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_SEARCH;
            region_q <= R_UNKNOWN;
            cnt_q    <= '0;
            tmax_q   <= '0;
            tmin_q   <= '0;
            div_q    <= '0;
            pk_q     <= '0;
            tr_q     <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            quo_q    <= '0;
            iter_q   <= '0;
            mv_q     <= 1'b0;
            to_q     <= 1'b0;
            period_q <= '0;
            tw_q     <= '0;
            peak_q   <= '0;
            trough_q <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            region_q <= region_d;
            cnt_q    <= cnt_d;
            tmax_q   <= tmax_d;
            tmin_q   <= tmin_d;
            div_q    <= div_d;
            pk_q     <= pk_d;
            tr_q     <= tr_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            quo_q    <= quo_d;
            iter_q   <= iter_d;
            mv_q     <= mv_d;
            to_q     <= to_d;
            period_q <= period_d;
            tw_q     <= tw_d;
            peak_q   <= peak_d;
            trough_q <= trough_d;
            locked_q <= locked_d;
        end
    end
endmodule

// File: tb/tb_sine_period_detector.sv
// Self-checking bench for sine_period_detector: constant-expectation tables,
// directed sine/timeout/reset sequences and a random run against a model.
module tb_sine_period_detector;
    localparam int MAXP = 4095;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sine_period_detector_if io();

    sine_period_detector #(
        .MID(100), .HYST(8), .MAX_PERIOD(MAXP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .io(io)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on the list of samples since the last crossing and a
    // "busy until cycle" window for the divider.
    int m_reg = 0;
    bit m_trk = 0;
    int m_q[$];
    int m_busy = -1, m_due = -1, m_cyc = 0;
    int m_per = 0, m_tw = 0, m_pk = 0, m_tr = 0, m_lock = 0, m_mv = 0, m_to = 0;
    int p_per = 0, p_tw = 0, p_pk = 0, p_tr = 0;
    int ms, mnr, mmx, mmn;
    bit mev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg = 0; m_trk = 0; m_q.delete();
            m_busy = -1; m_due = -1;
            m_per = 0; m_tw = 0; m_pk = 0; m_tr = 0;
            m_lock = 0; m_mv = 0; m_to = 0;
        end else begin
            m_cyc++;
            m_mv = 0;
            m_to = 0;
            if (io.sample_valid) begin
                ms = int'(io.sample);
                mnr = (ms >= 108) ? 2 : ((ms <= 92) ? 1 : m_reg);
                mev = (m_reg == 1) && (mnr == 2);
                if (!m_trk) begin
                    if (mev) begin
                        m_trk = 1;
                        m_q = {ms};
                    end
                end else if (mev) begin
                    if (m_cyc > m_busy) begin
                        mmx = ms; mmn = ms;
                        foreach (m_q[i]) begin
                            if (m_q[i] > mmx) mmx = m_q[i];
                            if (m_q[i] < mmn) mmn = m_q[i];
                        end
                        p_per = m_q.size();
                        p_tw = (p_per == 1) ? 1023 : 1024 / p_per;
                        p_pk = mmx; p_tr = mmn;
                        m_due = m_cyc + 12;
                        m_busy = m_cyc + 12;
                    end
                    m_q = {ms};
                end else if (m_q.size() + 1 == MAXP) begin
                    m_to = 1; m_lock = 0; mnr = 0; m_trk = 0;
                    m_due = -1; m_busy = -1;
                    m_q.delete();
                end else begin
                    m_q.push_back(ms);
                end
                m_reg = mnr;
            end
            if (m_due == m_cyc) begin
                m_per = p_per; m_tw = p_tw; m_pk = p_pk; m_tr = p_tr;
                m_mv = 1; m_lock = 1; m_due = -1;
            end
        end
    end

    // every cycle: DUT outputs against the model
    always @(negedge clk) begin
        chk("mon_meas_valid", int'(io.meas_valid), m_mv);
        chk("mon_timeout", int'(io.timeout), m_to);
        chk("mon_locked", int'(io.locked), m_lock);
        chk("mon_period", int'(io.period), m_per);
        chk("mon_tuning_word", int'(io.tuning_word), m_tw);
        chk("mon_peak", int'(io.peak), m_pk);
        chk("mon_trough", int'(io.trough), m_tr);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(bit v, int s);
        @(negedge clk);
        io.sample_valid = v;
        io.sample = 10'(s);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        io.sample_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic chk_zero(string nm);
        chk({nm, "_mv"}, int'(io.meas_valid), 0);
        chk({nm, "_to"}, int'(io.timeout), 0);
        chk({nm, "_locked"}, int'(io.locked), 0);
        chk({nm, "_period"}, int'(io.period), 0);
        chk({nm, "_tw"}, int'(io.tuning_word), 0);
        chk({nm, "_peak"}, int'(io.peak), 0);
        chk({nm, "_trough"}, int'(io.trough), 0);
    endtask

    function automatic int sine_val(int k, int n);
        real x;
        x = 100.0 + 100.0 * $sin(2.0 * 3.14159265358979 * real'(k) / real'(n));
        return $rtoi(x + 0.5);
    endfunction

    typedef struct {
        int p; int hi; int lo;
        int eper; int etw; int epk; int etr;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int k, got, nmv, last, gap, n, lo, hi, per, dens, len, s;

        tbl[0] = '{2,    200,  0,  2,    512, 200,  0};
        tbl[1] = '{3,    150,  20, 3,    341, 150,  20};
        tbl[2] = '{5,    108,  92, 5,    204, 108,  92};
        tbl[3] = '{7,    1023, 0,  7,    146, 1023, 0};
        tbl[4] = '{16,   120,  50, 16,   64,  120,  50};
        tbl[5] = '{100,  300,  10, 100,  10,  300,  10};
        tbl[6] = '{1000, 200,  0,  1000, 1,   200,  0};
        tbl[7] = '{4094, 200,  0,  4094, 0,   200,  0};

        io.sample_valid = 1'b0;
        io.sample = '0;
        repeat (3) @(negedge clk);
        #2;
        chk_zero("reset_state");
        rst_n = 1'b1;

        // square waves with fixed expectations
        foreach (tbl[r]) begin
            do_reset();
            k = 0;
            got = 0;
            for (int c = 0; c < 3 * tbl[r].p + 40 && got == 0; c++) begin
                step(1'b1, (k % tbl[r].p == 0) ? tbl[r].hi : tbl[r].lo);
                k++;
                if (io.meas_valid) got = 1;
            end
            chk("tbl_meas_seen", got, 1);
            chk("tbl_period", int'(io.period), tbl[r].eper);
            chk("tbl_tw", int'(io.tuning_word), tbl[r].etw);
            chk("tbl_peak", int'(io.peak), tbl[r].epk);
            chk("tbl_trough", int'(io.trough), tbl[r].etr);
            chk("tbl_locked", int'(io.locked), 1);
        end

        // ideal sine, 16 samples per cycle, every clock
        do_reset();
        nmv = 0; last = -1; gap = 0;
        for (int i = 0; i < 16 * 8; i++) begin
            step(1'b1, sine_val(i, 16));
            if (io.meas_valid) begin
                if (last >= 0) gap = i - last;
                last = i;
                nmv++;
            end
        end
        chk("sine16_count", int'(nmv >= 5), 1);
        chk("sine16_gap", gap, 16);
        chk("sine16_period", int'(io.period), 16);
        chk("sine16_tw", int'(io.tuning_word), 64);
        chk("sine16_peak", int'(io.peak), 200);
        chk("sine16_trough", int'(io.trough), 0);
        chk("sine16_locked", int'(io.locked), 1);

        // 10 samples per cycle, valid every other clock
        do_reset();
        nmv = 0; last = -1; gap = 0; k = 0;
        for (int i = 0; i < 20 * 8; i++) begin
            if (i % 2 == 0) begin
                step(1'b1, sine_val(k, 10));
                k++;
            end else begin
                step(1'b0, int'($urandom_range(0, 300)));
            end
            if (io.meas_valid) begin
                if (last >= 0) gap = i - last;
                last = i;
                nmv++;
            end
        end
        chk("sine10_count", int'(nmv >= 5), 1);
        chk("sine10_gap", gap, 20);
        chk("sine10_period", int'(io.period), 10);
        chk("sine10_tw", int'(io.tuning_word), 102);

        // asynchronous reset mid-stream, checked before any clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // lock, then hover inside the hysteresis band until timeout
        for (int i = 0; i < 48; i++) step(1'b1, sine_val(i, 16));
        chk("pre_to_locked", int'(io.locked), 1);
        step(1'b1, 0);
        step(1'b1, 200);
        n = 0;
        got = 0;
        while (n < 4200 && got == 0) begin
            step(1'b1, (n % 2 == 0) ? 98 : 103);
            n++;
            if (io.timeout) got = 1;
        end
        chk("timeout_sample", n, 4094);
        chk("timeout_locked", int'(io.locked), 0);
        step(1'b1, 98);
        chk("timeout_one_cycle", int'(io.timeout), 0);

        // reset five clocks into a divide
        do_reset();
        step(1'b1, 200);
        step(1'b1, 0);
        step(1'b1, 200);
        step(1'b1, 0);
        step(1'b1, 200);
        for (int i = 0; i < 5; i++) step(1'b1, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("div_reset");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        nmv = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 0);
            if (io.meas_valid) nmv++;
        end
        chk("div_reset_no_meas", nmv, 0);
        for (int i = 0; i < 64; i++) step(1'b1, sine_val(i, 16));
        chk("relock_period", int'(io.period), 16);
        chk("relock_tw", int'(io.tuning_word), 64);
        chk("relock_locked", int'(io.locked), 1);

        // random waveforms against the model
        for (int seg = 0; seg < 30; seg++) begin
            if ($urandom_range(0, 9) == 0) do_reset();
            per = int'($urandom_range(2, 30));
            hi = int'($urandom_range(108, 400));
            lo = int'($urandom_range(0, 92));
            dens = int'($urandom_range(1, 3));
            len = per * int'($urandom_range(2, 5)) * dens;
            k = 0;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(1, dens) == 1) begin
                    s = (k % per < (per + 1) / 2) ? hi : lo;
                    if ($urandom_range(0, 19) == 0) s = int'($urandom_range(0, 255));
                    step(1'b1, s);
                    k++;
                end else begin
                    step(1'b0, int'($urandom_range(0, 1023)));
                end
            end
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
